// File: rtl/fire_pkg.sv
// Shared sizing constants and controller state encoding for the fire4 concat writers.
package fire_pkg;

    localparam int DSP_NO   = 128;
    localparam int WIDTH    = 16;
    localparam int LANES    = 8;
    localparam int PIXELS   = 1024;
    localparam int CH_TOTAL = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counter width that never collapses to zero bits for degenerate sizes.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/fire4_concat_writer.sv
// Captures one expand-layer pixel vector and streams it, LANES channels per beat,
// into its channel slot of the concatenated fire4 feature map.
module fire4_concat_writer #(
    parameter int DSP_NO    = fire_pkg::DSP_NO,
    parameter int WIDTH     = fire_pkg::WIDTH,
    parameter int LANES     = fire_pkg::LANES,
    parameter int PIXELS    = fire_pkg::PIXELS,
    parameter int CH_TOTAL  = fire_pkg::CH_TOTAL,
    parameter int CH_OFFSET = 0
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     en,
    input  logic                                     ofm_valid,
    input  logic [WIDTH-1:0]                         ofm [DSP_NO],
    input  logic                                     wr_ready,
    output logic                                     wr_en,
    output logic [$clog2(PIXELS*CH_TOTAL/LANES)-1:0] wr_addr,
    output logic [LANES*WIDTH-1:0]                   wr_data,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     overrun
);

    import fire_pkg::*;

    localparam int BEATS      = DSP_NO / LANES;
    localparam int ADDR_W     = $clog2(PIXELS * CH_TOTAL / LANES);
    localparam int PIX_W      = clog2_min1(PIXELS);
    localparam int BEAT_W     = clog2_min1(BEATS);
    localparam int IDX_W      = clog2_min1(DSP_NO);
    localparam int PIX_STRIDE = CH_TOTAL / LANES;
    localparam int SLOT_BASE  = CH_OFFSET / LANES;

    state_t                 r_state;
    logic [PIX_W-1:0]       r_pix;
    logic [BEAT_W-1:0]      r_beat;
    logic [WIDTH-1:0]       r_buf [DSP_NO];
    logic                   r_wr_en;
    logic [ADDR_W-1:0]      r_wr_addr;
    logic [LANES*WIDTH-1:0] r_wr_data;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_overrun;

    logic                   w_vec_in;
    logic                   w_accept;
    logic                   w_last_beat;
    logic                   w_last_pix;
    logic                   w_chain;
    logic                   w_capture;
    logic [PIX_W-1:0]       w_cap_pix;
    logic [ADDR_W-1:0]      w_cap_addr;
    logic [BEAT_W-1:0]      w_beat_nxt;
    logic [IDX_W-1:0]       w_nxt_base;
    logic [LANES*WIDTH-1:0] w_cap_data;
    logic [LANES*WIDTH-1:0] w_nxt_data;

    assign w_vec_in    = en & ofm_valid;
    assign w_accept    = r_wr_en & wr_ready;
    assign w_last_beat = (r_beat == BEAT_W'(BEATS - 1));
    assign w_last_pix  = (r_pix == PIX_W'(PIXELS - 1));

    // A vector arriving exactly as the final beat leaves is taken back-to-back.
    assign w_chain   = (r_state == DRAIN) & w_accept & w_last_beat & ~w_last_pix & w_vec_in;
    assign w_capture = ((r_state == IDLE) & w_vec_in) | w_chain;

    assign w_cap_pix  = (r_state == DRAIN) ? r_pix + 1'b1 : r_pix;
    assign w_cap_addr = ADDR_W'(w_cap_pix) * ADDR_W'(PIX_STRIDE) + ADDR_W'(SLOT_BASE);
    assign w_beat_nxt = r_beat + 1'b1;
    assign w_nxt_base = IDX_W'(w_beat_nxt) * IDX_W'(LANES);

    // Beat 0 comes straight from the input so the first write needs no extra cycle.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign w_cap_data[gi*WIDTH +: WIDTH] = ofm[gi];
        assign w_nxt_data[gi*WIDTH +: WIDTH] = r_buf[w_nxt_base + IDX_W'(gi)];
    end

    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_buf <= ofm;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_pix     <= '0;
            r_beat    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_vec_in) begin
                        r_state   <= DRAIN;
                        r_beat    <= '0;
                        r_wr_en   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_wr_addr <= w_cap_addr;
                        r_wr_data <= w_cap_data;
                    end
                end
                DRAIN: begin
                    if (w_vec_in && !w_chain) begin
                        r_overrun <= 1'b1;
                    end
                    if (w_accept) begin
                        if (!w_last_beat) begin
                            r_beat    <= w_beat_nxt;
                            r_wr_addr <= r_wr_addr + 1'b1;
                            r_wr_data <= w_nxt_data;
                        end else begin
                            r_pix <= r_pix + 1'b1;
                            if (w_last_pix) begin
                                r_state <= DONE;
                                r_wr_en <= 1'b0;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else if (w_chain) begin
                                r_beat    <= '0;
                                r_wr_addr <= w_cap_addr;
                                r_wr_data <= w_cap_data;
                            end else begin
                                r_state <= IDLE;
                                r_wr_en <= 1'b0;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                end
                DONE: begin
                    r_done <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign busy    = r_busy;
    assign done    = r_done;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_fire4_concat_writer.sv
// Bench for fire4_concat_writer: two instances (channel slot 0 and 128) share one stimulus
// and are compared every cycle against a beat-queue model, plus hand-computed literals.
module tb_fire4_concat_writer;

    localparam int DSP_NO = 128;
    localparam int WIDTH  = 16;
    localparam int LANES  = 8;
    localparam int PIXELS = 1024;
    localparam int BEATS  = 16;
    localparam int STRIDE = 32;
    localparam int AW     = 15;
    localparam int DW     = 128;
    localparam int NPIN   = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst       = 1'b0;
    logic             en        = 1'b0;
    logic             ofm_valid = 1'b0;
    logic             wr_ready  = 1'b1;
    logic [WIDTH-1:0] ofm [DSP_NO];

    logic          lo_wr_en, lo_busy, lo_done, lo_overrun;
    logic [AW-1:0] lo_wr_addr;
    logic [DW-1:0] lo_wr_data;
    logic          hi_wr_en, hi_busy, hi_done, hi_overrun;
    logic [AW-1:0] hi_wr_addr;
    logic [DW-1:0] hi_wr_data;

    fire4_concat_writer #(.CH_OFFSET(0)) u_lo (
        .clk(clk), .rst(rst), .en(en), .ofm_valid(ofm_valid), .ofm(ofm),
        .wr_ready(wr_ready), .wr_en(lo_wr_en), .wr_addr(lo_wr_addr),
        .wr_data(lo_wr_data), .busy(lo_busy), .done(lo_done), .overrun(lo_overrun)
    );

    fire4_concat_writer #(.CH_OFFSET(128)) u_hi (
        .clk(clk), .rst(rst), .en(en), .ofm_valid(ofm_valid), .ofm(ofm),
        .wr_ready(wr_ready), .wr_en(hi_wr_en), .wr_addr(hi_wr_addr),
        .wr_data(hi_wr_data), .busy(hi_busy), .done(hi_done), .overrun(hi_overrun)
    );

    typedef struct {
        int            pix;
        int            beat;
        logic [DW-1:0] data;
    } beat_t;

    beat_t exp_q[$];
    int    m_pix  = 0;
    bit    m_done = 1'b0;
    bit    m_ovr  = 1'b0;

    string        pin_nm  [NPIN];
    logic [159:0] pin_act [NPIN];
    logic [159:0] pin_exp [NPIN];
    int           pin_cnt  = 0;
    int           pin_done = 0;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            acc_cnt  = 0;
    logic [AW-1:0] last_lo  = '0;
    logic [AW-1:0] last_hi  = '0;
    bit            cmp_on   = 1'b0;

    task automatic push_vec();
        beat_t e;
        for (int b = 0; b < BEATS; b++) begin
            e.pix  = m_pix;
            e.beat = b;
            for (int k = 0; k < LANES; k++) e.data[k*WIDTH +: WIDTH] = ofm[b*LANES + k];
            exp_q.push_back(e);
        end
    endtask

    // Model: a vector becomes a queue of 16 writes; a write leaves when the memory takes it.
    initial forever begin
        bit vec;
        bit fin;
        @(posedge clk or negedge rst);
        if (!rst) begin
            exp_q.delete();
            m_pix  = 0;
            m_done = 1'b0;
            m_ovr  = 1'b0;
        end else if (!m_done) begin
            vec = en && ofm_valid;
            if (exp_q.size() == 0) begin
                if (vec) push_vec();
            end else begin
                fin = wr_ready && (exp_q.size() == 1);
                if (wr_ready) void'(exp_q.pop_front());
                if (fin) begin
                    m_pix++;
                    if (m_pix == PIXELS) m_done = 1'b1;
                    else if (vec) begin
                        push_vec();
                        vec = 1'b0;
                    end
                end
                if (vec) m_ovr = 1'b1;
            end
        end
    end

    // Single compare process: pinned literals first, then both instances against the model.
    initial forever begin
        logic          exp_we;
        logic [AW-1:0] ea_lo;
        logic [AW-1:0] ea_hi;
        logic [DW-1:0] ed;
        logic [159:0]  e_lo, e_hi, a_lo, a_hi;
        @(negedge clk);
        while (pin_done < pin_cnt) begin
            n_checks++;
            if (pin_act[pin_done] !== pin_exp[pin_done]) begin
                n_fail++;
                $display("FAIL %s actual=%0h required=%0h t=%0t",
                         pin_nm[pin_done], pin_act[pin_done], pin_exp[pin_done], $time);
            end
            pin_done++;
        end
        if (cmp_on) begin
            exp_we = (exp_q.size() > 0);
            ea_lo  = '0;
            ea_hi  = '0;
            ed     = '0;
            if (exp_we) begin
                ea_lo = AW'(exp_q[0].pix * STRIDE + exp_q[0].beat);
                ea_hi = AW'(exp_q[0].pix * STRIDE + 128 / LANES + exp_q[0].beat);
                ed    = exp_q[0].data;
            end
            e_lo = {13'd0, exp_we, exp_we, m_done, m_ovr, ea_lo, ed};
            e_hi = {13'd0, exp_we, exp_we, m_done, m_ovr, ea_hi, ed};
            a_lo = {13'd0, lo_wr_en, lo_busy, lo_done, lo_overrun,
                    exp_we ? lo_wr_addr : {AW{1'b0}}, exp_we ? lo_wr_data : {DW{1'b0}}};
            a_hi = {13'd0, hi_wr_en, hi_busy, hi_done, hi_overrun,
                    exp_we ? hi_wr_addr : {AW{1'b0}}, exp_we ? hi_wr_data : {DW{1'b0}}};
            n_checks += 2;
            if (a_lo !== e_lo) begin
                n_fail++;
                $display("FAIL stream_lo actual=%0h required=%0h t=%0t", a_lo, e_lo, $time);
            end
            if (a_hi !== e_hi) begin
                n_fail++;
                $display("FAIL stream_hi actual=%0h required=%0h t=%0t", a_hi, e_hi, $time);
            end
            if (lo_wr_en && wr_ready) begin
                acc_cnt++;
                last_lo = lo_wr_addr;
                last_hi = hi_wr_addr;
            end
        end
    end

    task automatic pin(input string nm, input logic [159:0] act, input logic [159:0] exp);
        if (pin_cnt < NPIN) begin
            pin_nm[pin_cnt]  = nm;
            pin_act[pin_cnt] = act;
            pin_exp[pin_cnt] = exp;
            pin_cnt++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int base);
        for (int i = 0; i < DSP_NO; i++) ofm[i] = WIDTH'(base + i);
        ofm_valid = 1'b1;
        tick();
        ofm_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (lo_busy && n < 100) begin
            tick();
            n++;
        end
        pin("drain_bound", 160'(n < 100), 160'd1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        int base;
        for (int i = 0; i < DSP_NO; i++) ofm[i] = '0;
        rst = 1'b0;
        repeat (3) tick();
        cmp_on = 1'b1;
        rst    = 1'b1;
        tick();
        pin("reset_state", 160'({lo_wr_en, lo_busy, lo_done, lo_overrun, lo_wr_addr, lo_wr_data}), 160'd0);

        // A: one vector ofm[i]=i; en dropped mid-drain must not abort it
        en   = 1'b1;
        base = acc_cnt;
        send(0);
        pin("A_first_addr_lo", 160'(lo_wr_addr), 160'd0);
        pin("A_first_addr_hi", 160'(hi_wr_addr), 160'd16);
        pin("A_first_data", 160'(lo_wr_data), 160'h0007_0006_0005_0004_0003_0002_0001_0000);
        en = 1'b0;
        wait_idle();
        en = 1'b1;
        pin("A_beats", 160'(acc_cnt - base), 160'd16);
        pin("A_last_addr", 160'({last_lo, last_hi}), 160'({15'd15, 15'd31}));
        pin("A_idle", 160'({lo_wr_en, lo_busy}), 160'd0);
        $display("scenario A: single vector, beats=%0d last_addr=%0d", acc_cnt - base, last_lo);

        // B: second pixel lands at 32.. (slot 0) and 48..63 (slot 128)
        send(16'h100);
        pin("B_first_addr_hi", 160'(hi_wr_addr), 160'd48);
        wait_idle();
        pin("B_last_addr", 160'({last_lo, last_hi}), 160'({15'd47, 15'd63}));
        $display("scenario B: second pixel, last_lo=%0d last_hi=%0d", last_lo, last_hi);

        en        = 1'b0;
        ofm_valid = 1'b1;
        tick();
        ofm_valid = 1'b0;
        en        = 1'b1;
        pin("en_low_ignored", 160'({lo_wr_en, lo_busy, lo_overrun}), 160'd0);
        $display("scenario en-low: strobe ignored, busy=%0d", lo_busy);

        // C: back-pressure for 3 cycles while beat 5 is presented
        do_reset();
        base = acc_cnt;
        send(16'h200);
        repeat (5) tick();
        wr_ready = 1'b0;
        repeat (3) begin
            tick();
            pin("C_hold_addr", 160'(lo_wr_addr), 160'd5);
            pin("C_hold_data", 160'(lo_wr_data), 160'h022F_022E_022D_022C_022B_022A_0229_0228);
        end
        wr_ready = 1'b1;
        wait_idle();
        pin("C_beats", 160'(acc_cnt - base), 160'd16);
        $display("scenario C: stall at beat 5, beats=%0d", acc_cnt - base);

        // D: strobe at beat 10 is dropped; strobe on final acceptance is chained
        do_reset();
        base = acc_cnt;
        send(16'h300);
        repeat (10) tick();
        send(16'h400);
        pin("D_overrun", 160'({lo_overrun, hi_overrun}), 160'd3);
        repeat (4) tick();
        send(16'h500);
        pin("D_chain_lo", 160'({lo_wr_en, lo_wr_addr}), 160'({1'b1, 15'd32}));
        pin("D_chain_hi", 160'(hi_wr_addr), 160'd48);
        pin("D_chain_data", 160'(lo_wr_data), 160'h0507_0506_0505_0504_0503_0502_0501_0500);
        wait_idle();
        pin("D_beats", 160'(acc_cnt - base), 160'd32);
        $display("scenario D: overrun then chained vector, beats=%0d", acc_cnt - base);

        // E: asynchronous reset at beat 7
        do_reset();
        send(16'h600);
        repeat (7) tick();
        #2;
        rst = 1'b0;
        #1;
        pin("E_async_reset", 160'({lo_wr_en, lo_busy, lo_wr_addr}), 160'd0);
        tick();
        rst = 1'b1;
        tick();
        send(16'h700);
        pin("E_restart", 160'({lo_wr_en, lo_wr_addr}), 160'({1'b1, 15'd0}));
        wait_idle();
        $display("scenario E: reset mid-drain, restart addr=0");

        // F: full layer at the 33-cycle upstream period
        do_reset();
        for (int p = 0; p < PIXELS; p++) begin
            for (int i = 0; i < DSP_NO; i++) ofm[i] = WIDTH'(p * 37 + i * 11);
            ofm_valid = 1'b1;
            tick();
            ofm_valid = 1'b0;
            repeat (32) tick();
        end
        pin("F_flags", 160'({lo_done, lo_overrun, lo_busy, hi_done, hi_overrun}), 160'b10010);
        pin("F_last_addr", 160'({last_lo, last_hi}), 160'({15'd32751, 15'd32767}));
        ofm_valid = 1'b1;
        tick();
        ofm_valid = 1'b0;
        repeat (2) tick();
        pin("F_after_done", 160'({lo_wr_en, lo_overrun, lo_done}), 160'b001);
        $display("scenario F: %0d vectors, last_lo=%0d last_hi=%0d done=%0d",
                 PIXELS, last_lo, last_hi, lo_done);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
